// File: rtl/alu_vector_checker.sv
`timescale 1ns/1ps
// alu_vector_checker
// Self-test engine for the ALU. It fetches 56-bit stimulus vectors from a
// vector ROM and drives the ALU operand and control ports. It samples the
// 22-bit ALU response ALU_LAT cycles later and compares it with the expected
// field of the vector. Each vector produces a one-cycle report. The engine
// also keeps saturating pass/fail totals and the id of the first failure.
module alu_vector_checker #(
    parameter int NUM_VECTORS  = 105,
    parameter int ADDR_W       = 7,
    parameter int ALU_LAT      = 2,
    parameter int CNT_W        = 8,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              VEC_RD,
    output logic [ADDR_W-1:0] VEC_ADDR,
    input  logic [55:0]       VEC_DATA,
    output logic              ALU_RST,
    output logic              ALU_CE,
    output logic              ALU_MODE,
    output logic              ALU_CIN,
    output logic [1:0]        ALU_INP_VALID,
    output logic [7:0]        ALU_OPA,
    output logic [7:0]        ALU_OPB,
    output logic [3:0]        ALU_CMD,
    input  logic [15:0]       ALU_RES,
    input  logic              ALU_COUT,
    input  logic              ALU_E,
    input  logic              ALU_G,
    input  logic              ALU_L,
    input  logic              ALU_OFLOW,
    input  logic              ALU_ERR,
    output logic              RPT_VALID,
    output logic [7:0]        RPT_ID,
    output logic              RPT_PASS,
    output logic [21:0]       RPT_RESP,
    output logic [CNT_W-1:0]  PASS_CNT,
    output logic [CNT_W-1:0]  FAIL_CNT,
    output logic              FIRST_FAIL_VALID,
    output logic [7:0]        FIRST_FAIL_ID
);

    localparam int WAIT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t              state;
    state_t              next_state;

    logic [ADDR_W-1:0]   ptr;
    logic [55:0]         vec_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]    pass_cnt;
    logic [CNT_W-1:0]    fail_cnt;
    logic                ff_valid;
    logic [7:0]          ff_id;

    logic [21:0]         resp;
    logic                match;
    logic                last_vec;
    logic                wait_done;
    logic                run_end;

    // Response as seen by the ALU this cycle, and the decisions made in CHECK.
    assign resp      = {ALU_RES, ALU_COUT, ALU_E, ALU_G, ALU_L, ALU_OFLOW, ALU_ERR};
    assign match     = (resp == vec_q[21:0]);
    assign last_vec  = (ptr == ADDR_W'(NUM_VECTORS - 1));
    assign wait_done = (wait_cnt == WAIT_W'(ALU_LAT - 1));
    assign run_end   = last_vec || ((STOP_ON_FAIL != 0) && !match);

    // State register; reset aborts any run immediately.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic for the fetch / load / wait / check sequence.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (START) next_state = S_FETCH;
            S_FETCH: next_state = S_LOAD;
            S_LOAD:  next_state = S_WAIT;
            S_WAIT:  if (wait_done) next_state = S_CHECK;
            S_CHECK: next_state = run_end ? S_DONE : S_FETCH;
            S_DONE:  if (START) next_state = S_FETCH;
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: vector pointer, captured vector, latency counter, run totals.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr      <= '0;
            vec_q    <= '0;
            wait_cnt <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            ff_valid <= 1'b0;
            ff_id    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        ptr      <= '0;
                        pass_cnt <= '0;
                        fail_cnt <= '0;
                        ff_valid <= 1'b0;
                        ff_id    <= '0;
                    end
                end
                S_LOAD: begin
                    vec_q    <= VEC_DATA;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                S_CHECK: begin
                    if (match) begin
                        if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
                    end else begin
                        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                        if (!ff_valid) begin
                            ff_valid <= 1'b1;
                            ff_id    <= vec_q[55:48];
                        end
                    end
                    if (!run_end) ptr <= ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        BUSY      = 1'b0;
        DONE      = 1'b0;
        VEC_RD    = 1'b0;
        RPT_VALID = 1'b0;
        RPT_ID    = '0;
        RPT_PASS  = 1'b0;
        RPT_RESP  = '0;
        case (state)
            S_FETCH: begin
                BUSY   = 1'b1;
                VEC_RD = 1'b1;
            end
            S_LOAD, S_WAIT: begin
                BUSY = 1'b1;
            end
            S_CHECK: begin
                BUSY      = 1'b1;
                RPT_VALID = 1'b1;
                RPT_ID    = vec_q[55:48];
                RPT_PASS  = match;
                RPT_RESP  = resp;
            end
            S_DONE: begin
                DONE = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU drive fields come straight from the captured vector, so they hold
    // between vectors and after the run ends.
    assign ALU_RST       = vec_q[47];
    assign ALU_INP_VALID = vec_q[46:45];
    assign ALU_OPA       = vec_q[44:37];
    assign ALU_OPB       = vec_q[36:29];
    assign ALU_CMD       = vec_q[28:25];
    assign ALU_CIN       = vec_q[24];
    assign ALU_CE        = vec_q[23];
    assign ALU_MODE      = vec_q[22];

    assign VEC_ADDR         = ptr;
    assign PASS_CNT         = pass_cnt;
    assign FAIL_CNT         = fail_cnt;
    assign FIRST_FAIL_VALID = ff_valid;
    assign FIRST_FAIL_ID    = ff_id;

endmodule
